// File: rtl/l3_arb_pkg.sv
// Shared types and widths for the L3 request arbiter.
package l3_arb_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } l3_arb_state_e;

  // Request captured at grant time and replayed to the slice.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } l3_req_t;

endpackage

// File: rtl/l3_rr_picker.sv
// Combinational round-robin picker: first request above last_grant, with wrap.
module l3_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IdxW-1:0]    gnt_idx_o,
  output logic               any_o
);

  logic [IdxW-1:0] cand;

  // Scan last_grant+1 .. last_grant+NUM_REQ; the first hit wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_grant_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o           = 1'b1;
        gnt_idx_o       = cand;
        gnt_oh_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l3_req_arbiter.sv
// Shares one L3 slice port among NUM_REQ requesters, one transaction in flight.
module l3_req_arbiter
  import l3_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]             req_write_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]             resp_valid_o,
  input  logic [NUM_REQ-1:0]             resp_ready_i,
  output logic [DATA_W-1:0]              resp_rdata_o,
  output logic                           resp_err_o,
  output logic                           l3_req_valid_o,
  output logic [ADDR_W-1:0]              l3_req_addr_o,
  output logic                           l3_req_write_o,
  output logic [DATA_W-1:0]              l3_req_wdata_o,
  output logic                           l3_resp_ready_o,
  input  logic                           l3_resp_valid_i,
  input  logic [DATA_W-1:0]              l3_resp_rdata_i,
  output logic                           busy_o
);

  localparam int unsigned     IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned     TmrW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmrW-1:0] TmrLast  = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_REQ - 1);

  l3_arb_state_e state_q, state_d;
  l3_req_t       req_q, req_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_grant_q, last_grant_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;

  l3_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_picker (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .gnt_oh_o     (pick_oh),
    .gnt_idx_o    (pick_idx),
    .any_o        (pick_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a response arriving on the timeout cycle still wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (l3_resp_valid_i || (timer_q == TmrLast)) state_d = RESP;
      RESP:    if (resp_ready_i[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: request latch, owner, round-robin pointer, timer, response.
  always_comb begin
    req_d        = req_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_d.addr  = req_addr_i[pick_idx];
          req_d.write = req_write_i[pick_idx];
          req_d.wdata = req_wdata_i[pick_idx];
          owner_d     = pick_idx;
        end
      end
      ISSUE: timer_d = '0;
      WAIT: begin
        if (l3_resp_valid_i) begin
          rdata_d = l3_resp_rdata_i;
          err_d   = 1'b0;
        end else if (timer_q == TmrLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP:    if (resp_ready_i[owner_q]) last_grant_d = owner_q;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= LastInit;
      timer_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      req_q        <= req_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Outputs decoded from state; everything outside its own state is held at 0.
  always_comb begin
    req_ready_o     = '0;
    resp_valid_o    = '0;
    resp_rdata_o    = '0;
    resp_err_o      = 1'b0;
    l3_req_valid_o  = 1'b0;
    l3_req_addr_o   = '0;
    l3_req_write_o  = 1'b0;
    l3_req_wdata_o  = '0;
    l3_resp_ready_o = 1'b0;
    busy_o          = (state_q != IDLE);
    unique case (state_q)
      // Masked during reset so no accept strobe is seen for a request that will not be taken.
      IDLE: if (!rst) req_ready_o = pick_oh;
      ISSUE: begin
        l3_req_valid_o  = 1'b1;
        l3_resp_ready_o = 1'b1;
        l3_req_addr_o   = req_q.addr;
        l3_req_write_o  = req_q.write;
        l3_req_wdata_o  = req_q.wdata;
      end
      RESP: begin
        resp_valid_o[owner_q] = 1'b1;
        resp_rdata_o          = rdata_q;
        resp_err_o            = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l3_req_arbiter.sv
// Self-checking bench for l3_req_arbiter with a 1-cycle memory model of the slice.
module tb_l3_req_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid_i;
  logic [3:0]       req_ready_o;
  logic [3:0][63:0] req_addr_i;
  logic [3:0]       req_write_i;
  logic [3:0][63:0] req_wdata_i;
  logic [3:0]       resp_valid_o;
  logic [3:0]       resp_ready_i;
  logic [63:0]      resp_rdata_o;
  logic             resp_err_o;
  logic             l3_req_valid_o;
  logic [63:0]      l3_req_addr_o;
  logic             l3_req_write_o;
  logic [63:0]      l3_req_wdata_o;
  logic             l3_resp_ready_o;
  logic             l3_resp_valid_i;
  logic [63:0]      l3_resp_rdata_i;
  logic             busy_o;

  l3_req_arbiter #(
    .NUM_REQ     (4),
    .TIMEOUT_CYC (15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_write_i     (req_write_i),
    .req_wdata_i     (req_wdata_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_rdata_o    (resp_rdata_o),
    .resp_err_o      (resp_err_o),
    .l3_req_valid_o  (l3_req_valid_o),
    .l3_req_addr_o   (l3_req_addr_o),
    .l3_req_write_o  (l3_req_write_o),
    .l3_req_wdata_o  (l3_req_wdata_o),
    .l3_resp_ready_o (l3_resp_ready_o),
    .l3_resp_valid_i (l3_resp_valid_i),
    .l3_resp_rdata_i (l3_resp_rdata_i),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slice model: answers one cycle after a handshake; writes return 0.
  logic        slice_en;
  logic        stray_valid;
  logic        model_valid;
  logic [63:0] model_rdata;
  logic [63:0] slice_mem [512];

  always @(posedge clk) begin
    if (rst) begin
      model_valid <= 1'b0;
    end else begin
      model_valid <= slice_en && l3_req_valid_o && l3_resp_ready_o;
      if (slice_en && l3_req_valid_o && l3_resp_ready_o) begin
        if (l3_req_write_o) begin
          slice_mem[l3_req_addr_o[11:3]] <= l3_req_wdata_o;
          model_rdata <= '0;
        end else begin
          model_rdata <= slice_mem[l3_req_addr_o[11:3]];
        end
      end
    end
  end

  assign l3_resp_valid_i = model_valid | stray_valid;
  assign l3_resp_rdata_i = model_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expectation pushed at grant, popped at response handshake.
  typedef struct {
    int          owner;
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t        sb[$];
  logic [63:0] exp_mem [512];

  initial begin : monitor
    exp_t e;
    int   g;
    for (int i = 0; i < 512; i++) exp_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        if (|req_ready_o) begin
          g = 0;
          for (int k = 0; k < 4; k++) if (req_ready_o[k]) g = k;
          e.owner = g;
          e.err   = 1'b0;
          if (!slice_en) begin
            e.rdata = '0;
            e.err   = 1'b1;
          end else if (req_write_i[g]) begin
            exp_mem[req_addr_i[g][11:3]] = req_wdata_i[g];
            e.rdata = '0;
          end else begin
            e.rdata = exp_mem[req_addr_i[g][11:3]];
          end
          sb.push_back(e);
        end
        if (|(resp_valid_o & resp_ready_i)) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_resp", {60'd0, resp_valid_o}, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("sb_owner", {60'd0, resp_valid_o}, 64'd1 << e.owner);
            chk("sb_rdata", resp_rdata_o, e.rdata);
            chk("sb_err", {63'd0, resp_err_o}, {63'd0, e.err});
          end
        end
      end
    end
  end

  task automatic set_reqs(input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
    for (int k = 0; k < 4; k++) begin
      req_write_i[k] = wr;
      req_addr_i[k]  = addr;
      req_wdata_i[k] = wdata ^ 64'(k);
    end
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (|req_ready_o) begin
        for (int k = 0; k < 4; k++) if (req_ready_o[k]) g = k;
        break;
      end
    end
    n_checks++;
    if (g < 0) begin
      n_err++;
      $display("FAIL grant_wait: req_ready_o stayed %b for 20 cycles", req_ready_o);
    end else if (!$onehot(req_ready_o)) begin
      n_err++;
      $display("FAIL grant_onehot: req_ready_o=%b expected one-hot", req_ready_o);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_busy", {63'd0, busy_o}, 64'd0);
  endtask

  typedef struct {
    logic [3:0]  mask;
    int          gnt;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int g;
    int t0;
    int n;
    vecs[0] = '{4'b0001, 0, 1'b1, 64'h40,  64'hDEAD_BEEF};
    vecs[1] = '{4'b0001, 0, 1'b0, 64'h40,  64'h0};
    vecs[2] = '{4'b1111, 1, 1'b1, 64'h100, 64'hA5A5_A5A5_5A5A_5A5A};
    vecs[3] = '{4'b1111, 2, 1'b0, 64'h100, 64'h0};
    vecs[4] = '{4'b1001, 3, 1'b0, 64'h40,  64'h0};
    vecs[5] = '{4'b0110, 1, 1'b1, 64'h200, 64'h1234};
    vecs[6] = '{4'b1100, 2, 1'b0, 64'h200, 64'h0};
    vecs[7] = '{4'b0011, 0, 1'b0, 64'h100, 64'h0};
    vecs[8] = '{4'b1000, 3, 1'b1, 64'h40,  64'hCAFE};
    vecs[9] = '{4'b0001, 0, 1'b0, 64'h40,  64'h0};

    rst          = 1'b1;
    slice_en     = 1'b1;
    stray_valid  = 1'b0;
    resp_ready_i = 4'b1111;
    req_valid_i  = 4'b1111;
    set_reqs(1'b0, 64'h800, 64'h0);

    // Reset state: all outputs low even with requests pending.
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {req_ready_o, resp_valid_o, resp_err_o, l3_req_valid_o, l3_req_write_o,
         l3_resp_ready_o, busy_o}, '0);
    chk("reset_rdata", resp_rdata_o, '0);
    chk("reset_l3_addr", l3_req_addr_o, '0);
    @(posedge clk); #1 rst = 1'b0;

    // All requesters held: grants 0,1,2,3,0 every 4 cycles.
    t0 = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      chk("rr_grant", 64'(g), 64'(i % 4));
      if (i > 0) chk("rr_spacing", 64'(cyc - t0), 64'd4);
      t0 = cyc;
    end
    @(posedge clk); #1 req_valid_i = '0;
    wait_idle();

    // Table: grant order, issue timing and slice-side fields.
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      set_reqs(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      req_valid_i = vecs[v].mask;
      wait_grant(g);
      chk("vec_grant", 64'(g), 64'(vecs[v].gnt));
      @(posedge clk); #1 req_valid_i = '0;
      @(negedge clk);
      chk("vec_issue_valid", {62'd0, l3_req_valid_o, l3_resp_ready_o}, 64'd3);
      chk("vec_issue_addr", l3_req_addr_o, vecs[v].addr);
      chk("vec_issue_write", {63'd0, l3_req_write_o}, {63'd0, vecs[v].wr});
      chk("vec_issue_wdata", l3_req_wdata_o, vecs[v].wdata ^ 64'(vecs[v].gnt));
      @(negedge clk);
      chk("vec_wait_quiet", {59'd0, resp_valid_o, l3_req_valid_o}, 64'd0);
      @(negedge clk);
      chk("vec_resp_valid", {60'd0, resp_valid_o}, 64'd1 << vecs[v].gnt);
    end

    // Slice silent: error response 15 cycles after WAIT entry.
    slice_en = 1'b0;
    @(posedge clk); #1;
    set_reqs(1'b0, 64'h40, 64'h0);
    req_valid_i = 4'b0010;
    wait_grant(g);
    chk("timeout_grant", 64'(g), 64'd1);
    t0 = cyc;
    @(posedge clk); #1 req_valid_i = '0;
    n = 0;
    @(negedge clk);
    while (resp_valid_o == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", 64'(cyc - t0), 64'd17);
    chk("timeout_err", {63'd0, resp_err_o}, 64'd1);
    chk("timeout_rdata", resp_rdata_o, '0);
    wait_idle();
    slice_en = 1'b1;

    // Owner stalls the response for several cycles while another requester waits.
    resp_ready_i = 4'b1011;
    @(posedge clk); #1;
    set_reqs(1'b0, 64'h40, 64'h0);
    req_valid_i = 4'b0100;
    wait_grant(g);
    chk("stall_grant", 64'(g), 64'd2);
    @(posedge clk); #1 req_valid_i = 4'b0001;
    n = 0;
    @(negedge clk);
    while (resp_valid_o == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", {60'd0, resp_valid_o}, 64'b0100);
      chk("stall_rdata", resp_rdata_o, 64'hCAFE ^ 64'd3);
      chk("stall_err_ready", {59'd0, resp_err_o, req_ready_o}, 64'd0);
    end
    @(posedge clk); #1 resp_ready_i = 4'b1111;
    @(negedge clk);
    chk("stall_last_cycle", {60'd0, resp_valid_o}, 64'b0100);
    @(negedge clk);
    chk("stall_resume_grant", {60'd0, req_ready_o}, 64'b0001);
    @(posedge clk); #1 req_valid_i = '0;
    wait_idle();

    // Reset during WAIT drops the transaction and restores the pointer.
    slice_en = 1'b0;
    @(posedge clk); #1 req_valid_i = 4'b0010;
    wait_grant(g);
    chk("rstmid_grant", 64'(g), 64'd1);
    @(posedge clk); #1 req_valid_i = '0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_outputs",
        {req_ready_o, resp_valid_o, resp_err_o, l3_req_valid_o, l3_resp_ready_o, busy_o}, '0);
    chk("rstmid_rdata", resp_rdata_o, '0);

    // Late / stray slice response while idle is ignored.
    @(posedge clk); #1 stray_valid = 1'b1;
    @(negedge clk);
    chk("stray_quiet", {59'd0, resp_valid_o, busy_o}, 64'd0);
    @(posedge clk); #1 stray_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_after", {59'd0, resp_valid_o, busy_o}, 64'd0);
    end

    slice_en = 1'b1;
    @(posedge clk); #1 req_valid_i = 4'b0011;
    wait_grant(g);
    chk("post_reset_grant", 64'(g), 64'd0);
    @(posedge clk); #1 req_valid_i = '0;
    wait_idle();
    repeat (2) @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
